// File: rtl/edge_pkg.sv
// Shared types, constants and small arithmetic helpers for the Sobel window engine.
package edge_pkg;

    typedef logic [7:0]         pixel_t;
    typedef pixel_t [11:0]      window_t;
    typedef logic signed [10:0] grad_t;
    typedef logic [10:0]        mag_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GRAD = 2'd1,
        MAG  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam int     ROWS    = 3;
    localparam int     COLS    = 4;
    localparam pixel_t PIX_MAX = 8'd255;

    // Zero-extend an unsigned pixel into the signed gradient domain.
    function automatic grad_t widen_pix(input pixel_t p);
        return grad_t'({3'b000, p});
    endfunction

    // Absolute value of a gradient; -1020 is the most negative value, so no overflow.
    function automatic mag_t abs_grad(input grad_t g);
        mag_t r;
        if (g[10]) begin
            r = mag_t'(-g);
        end else begin
            r = mag_t'(g);
        end
        return r;
    endfunction

    // Map an 11-bit magnitude onto an output pixel: saturate, or binarize against thr.
    function automatic pixel_t shape_mag(input mag_t m, input logic binarize, input mag_t thr);
        pixel_t r;
        if (binarize) begin
            if (m >= thr) begin
                r = PIX_MAX;
            end else begin
                r = 8'd0;
            end
        end else begin
            if (m > mag_t'(PIX_MAX)) begin
                r = PIX_MAX;
            end else begin
                r = m[7:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sobel_window_engine_sobel_3x3.sv
// Combinational 3x3 Sobel kernel: nine pixels (index r*3+c) in, signed Gx/Gy out.
module sobel_3x3
    import edge_pkg::*;
(
    input  pixel_t [8:0] pix_i,
    output grad_t        gx_o,
    output grad_t        gy_o
);

    grad_t gx_s;
    grad_t gy_s;

    // Weighted column/row differences; all sums fit in 11 signed bits (max 1020).
    always_comb begin
        gx_s = 11'sd0;
        gy_s = 11'sd0;
        gx_s = (widen_pix(pix_i[2]) + widen_pix(pix_i[5]) + widen_pix(pix_i[5]) + widen_pix(pix_i[8]))
             - (widen_pix(pix_i[0]) + widen_pix(pix_i[3]) + widen_pix(pix_i[3]) + widen_pix(pix_i[6]));
        gy_s = (widen_pix(pix_i[6]) + widen_pix(pix_i[7]) + widen_pix(pix_i[7]) + widen_pix(pix_i[8]))
             - (widen_pix(pix_i[0]) + widen_pix(pix_i[1]) + widen_pix(pix_i[1]) + widen_pix(pix_i[2]));
    end

    assign gx_o = gx_s;
    assign gy_o = gy_s;

endmodule

// File: rtl/sobel_window_engine.sv
// Sobel window engine: snapshots a full 3x4 window, releases the fill buffer,
// computes two overlapping 3x3 gradient magnitudes and hands them downstream.
module sobel_window_engine
    import edge_pkg::*;
#(
    parameter logic        BINARIZE  = 1'b0,
    parameter logic [10:0] THRESHOLD = 11'd128
)
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic [11:0][7:0] data_buffer,
    input  logic             buffer_full,
    output logic             buffer_clear,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [1:0][7:0]  edge_pixels,
    output logic             busy,
    output logic [15:0]      window_count
);

    state_t        state_q, state_d;
    window_t       win_q, win_d;
    grad_t         gx_q [2];
    grad_t         gx_d [2];
    grad_t         gy_q [2];
    grad_t         gy_d [2];
    grad_t         gx_s [2];
    grad_t         gy_s [2];
    pixel_t [1:0]  edge_q, edge_d;
    logic          valid_q, valid_d;
    logic          clear_q, clear_d;
    logic          busy_q, busy_d;
    logic [15:0]   count_q, count_d;

    // Two kernels over the snapshot, at column offsets 0 and 1.
    for (genvar w = 0; w < 2; w++) begin : g_win
        pixel_t [8:0] tap_s;
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            for (genvar c = 0; c < 3; c++) begin : g_col
                assign tap_s[r*3 + c] = win_q[r*COLS + c + w];
            end
        end
        sobel_3x3 u_sobel (
            .pix_i (tap_s),
            .gx_o  (gx_s[w]),
            .gy_o  (gy_s[w])
        );
    end

    // Next-state and registered-output logic for the IDLE->GRAD->MAG->OUT sequence.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        gx_d[0]  = gx_q[0];
        gx_d[1]  = gx_q[1];
        gy_d[0]  = gy_q[0];
        gy_d[1]  = gy_q[1];
        edge_d   = edge_q;
        valid_d  = valid_q;
        clear_d  = 1'b0;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (buffer_full) begin
                    win_d   = data_buffer;
                    clear_d = 1'b1;
                    state_d = GRAD;
                end else begin
                    state_d = IDLE;
                end
            end
            GRAD: begin
                gx_d[0] = gx_s[0];
                gx_d[1] = gx_s[1];
                gy_d[0] = gy_s[0];
                gy_d[1] = gy_s[1];
                state_d = MAG;
            end
            MAG: begin
                edge_d[0] = shape_mag(abs_grad(gx_q[0]) + abs_grad(gy_q[0]), BINARIZE, mag_t'(THRESHOLD));
                edge_d[1] = shape_mag(abs_grad(gx_q[1]) + abs_grad(gy_q[1]), BINARIZE, mag_t'(THRESHOLD));
                valid_d   = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, snapshot, pipeline and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            gx_q[0] <= 11'sd0;
            gx_q[1] <= 11'sd0;
            gy_q[0] <= 11'sd0;
            gy_q[1] <= 11'sd0;
            edge_q  <= '0;
            valid_q <= 1'b0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            gx_q[0] <= gx_d[0];
            gx_q[1] <= gx_d[1];
            gy_q[0] <= gy_d[0];
            gy_q[1] <= gy_d[1];
            edge_q  <= edge_d;
            valid_q <= valid_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign buffer_clear = clear_q;
    assign out_valid    = valid_q;
    assign edge_pixels  = edge_q;
    assign busy         = busy_q;
    assign window_count = count_q;

endmodule

// File: tb/tb_sobel_window_engine.sv
// Scoreboard bench for sobel_window_engine: a saturating and a binarizing
// instance share stimulus; expectations come from a plain-arithmetic Sobel model.
module tb_sobel_window_engine;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [11:0][7:0] data_buffer;
    logic             buffer_full;
    logic             out_ready;

    logic             clr0, val0, busy0, clr1, val1, busy1;
    logic [1:0][7:0]  edge0, edge1;
    logic [15:0]      cnt0, cnt1;

    int n_pass  = 0;
    int n_total = 0;
    int n_sent  = 0;
    int n_clears = 0;
    int mode    = 0;   // 0: ready high, 1: random ready, 2: ready low

    logic [15:0] exp0_q[$];
    logic [15:0] exp1_q[$];

    always #5 clk = ~clk;

    sobel_window_engine #(.BINARIZE(1'b0), .THRESHOLD(11'd128)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .data_buffer(data_buffer), .buffer_full(buffer_full),
        .buffer_clear(clr0), .out_ready(out_ready), .out_valid(val0),
        .edge_pixels(edge0), .busy(busy0), .window_count(cnt0)
    );

    sobel_window_engine #(.BINARIZE(1'b1), .THRESHOLD(11'd128)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .data_buffer(data_buffer), .buffer_full(buffer_full),
        .buffer_clear(clr1), .out_ready(out_ready), .out_valid(val1),
        .edge_pixels(edge1), .busy(busy1), .window_count(cnt1)
    );

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Reference: Sobel on a 3x3 sub-window starting at column off.
    function automatic logic [7:0] ref_pix(input logic [11:0][7:0] w, input int off, input bit bin);
        int p[3][4];
        int gx, gy, mag, wt;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                p[r][c] = int'(w[r*4 + c]);
        gx = 0;
        gy = 0;
        for (int r = 0; r < 3; r++) begin
            wt = (r == 1) ? 2 : 1;
            gx += wt * (p[r][off+2] - p[r][off]);
        end
        for (int c = 0; c < 3; c++) begin
            wt = (c == 1) ? 2 : 1;
            gy += wt * (p[2][off+c] - p[0][off+c]);
        end
        mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        if (bin) return (mag >= 128) ? 8'd255 : 8'd0;
        return (mag > 255) ? 8'd255 : 8'(mag);
    endfunction

    function automatic logic [11:0][7:0] cols_win(input int a, input int b, input int c, input int d);
        logic [11:0][7:0] w;
        for (int r = 0; r < 3; r++) begin
            w[r*4 + 0] = 8'(a); w[r*4 + 1] = 8'(b);
            w[r*4 + 2] = 8'(c); w[r*4 + 3] = 8'(d);
        end
        return w;
    endfunction

    function automatic logic [11:0][7:0] rows_win(input int a, input int b, input int c);
        logic [11:0][7:0] w;
        for (int k = 0; k < 4; k++) begin
            w[k] = 8'(a); w[4 + k] = 8'(b); w[8 + k] = 8'(c);
        end
        return w;
    endfunction

    function automatic logic [11:0][7:0] rand_win(input bit low_contrast);
        logic [11:0][7:0] w;
        int base;
        base = $urandom_range(0, 200);
        for (int k = 0; k < 12; k++)
            w[k] = low_contrast ? 8'(base + $urandom_range(0, 40)) : 8'($urandom_range(0, 255));
        return w;
    endfunction

    // Present a window and record both expected results.
    task automatic issue(input logic [11:0][7:0] w);
        data_buffer = w;
        buffer_full = 1'b1;
        exp0_q.push_back({ref_pix(w, 1, 1'b0), ref_pix(w, 0, 1'b0)});
        exp1_q.push_back({ref_pix(w, 1, 1'b1), ref_pix(w, 0, 1'b1)});
        n_sent++;
    endtask

    // Wait for the clear pulse, then drop the request and scramble the buffer.
    task automatic wait_clear(output int k);
        bit seen;
        seen = 1'b0;
        for (k = 0; k < 60 && !seen; k++) begin
            @(negedge clk); #1;
            if (clr0) seen = 1'b1;
        end
        check(seen, "clear_seen", int'(seen), 1);
        buffer_full = 1'b0;
        data_buffer = {$urandom, $urandom, $urandom};
    endtask

    task automatic send_window(input logic [11:0][7:0] w, input bit lat);
        int k;
        issue(w);
        wait_clear(k);
        if (lat) begin
            check(k == 1, "clear_latency", k, 1);
            @(negedge clk); #1;
            check(!clr0, "clear_one_cycle", int'(clr0), 0);
            check(!val0, "valid_early", int'(val0), 0);
            @(negedge clk); #1;
            check(val0, "valid_latency", int'(val0), 1);
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200 && (busy0 || busy1); k++) begin
            @(negedge clk); #1;
        end
        check(!busy0 && !busy1, "idle_timeout", int'(busy0), 0);
    endtask

    // Ready generator.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks hold/count/pulse rules.
    initial begin
        int hs0, hs1;
        logic pv0, pr, pclr;
        logic [15:0] pe0, pe1, e;
        hs0 = 0; hs1 = 0; pv0 = 1'b0; pr = 1'b0; pclr = 1'b0; pe0 = 16'd0; pe1 = 16'd0;
        forever begin
            @(negedge clk); #2;
            if (!n_rst) begin
                exp0_q.delete();
                exp1_q.delete();
                hs0 = 0; hs1 = 0; pv0 = 1'b0; pr = 1'b0; pclr = 1'b0;
            end else begin
                check(cnt0 == 16'(hs0), "window_count0", int'(cnt0), hs0);
                check(cnt1 == 16'(hs1), "window_count1", int'(cnt1), hs1);
                if (clr0) begin
                    n_clears++;
                    check(!pclr, "double_clear", int'(pclr), 0);
                end
                if (pv0 && !pr) begin
                    check(val0, "hold_valid", int'(val0), 1);
                    check(16'(edge0) == pe0, "hold_edge0", int'(edge0), int'(pe0));
                    check(16'(edge1) == pe1, "hold_edge1", int'(edge1), int'(pe1));
                end
                if (val0 && out_ready) begin
                    if (exp0_q.size() == 0) check(1'b0, "unexpected_out0", int'(edge0), -1);
                    else begin
                        e = exp0_q.pop_front();
                        check(16'(edge0) == e, "edge_pixels_sat", int'(edge0), int'(e));
                    end
                    hs0++;
                end
                if (val1 && out_ready) begin
                    if (exp1_q.size() == 0) check(1'b0, "unexpected_out1", int'(edge1), -1);
                    else begin
                        e = exp1_q.pop_front();
                        check(16'(edge1) == e, "edge_pixels_bin", int'(edge1), int'(e));
                    end
                    hs1++;
                end
                pv0 = val0; pr = out_ready; pclr = clr0;
                pe0 = 16'(edge0); pe1 = 16'(edge1);
            end
        end
    end

    // Stimulus.
    initial begin
        int k;
        n_rst = 1'b0;
        buffer_full = 1'b0;
        data_buffer = '0;
        repeat (3) @(negedge clk);
        #1;
        check({clr0, val0, busy0, clr1, val1, busy1} == 6'd0, "reset_ctrl", int'({clr0, val0, busy0}), 0);
        check(edge0 == 16'd0 && cnt0 == 16'd0, "reset_data", int'(edge0), 0);
        n_rst = 1'b1;
        @(negedge clk); #1;

        // Directed patterns.
        mode = 0;
        send_window(cols_win(100, 100, 100, 100), 1'b1);
        wait_idle();
        send_window(cols_win(10, 10, 20, 20), 1'b1);
        wait_idle();
        send_window(rows_win(50, 0, 0), 1'b0);
        send_window(rows_win(0, 0, 255), 1'b0);
        send_window(cols_win(0, 0, 30, 30), 1'b0);    // mag 120
        send_window(cols_win(0, 0, 40, 40), 1'b0);    // mag 160
        wait_idle();

        // Backpressure with a second full window waiting during OUT.
        mode = 2;
        @(negedge clk); #1;
        send_window(cols_win(5, 60, 7, 200), 1'b0);
        for (k = 0; k < 20 && !val0; k++) begin @(negedge clk); #1; end
        check(val0, "bp_valid", int'(val0), 1);
        issue(rand_win(1'b0));
        repeat (5) begin
            @(negedge clk); #1;
            check(!clr0, "bp_no_clear", int'(clr0), 0);
        end
        mode = 0;
        wait_clear(k);
        wait_idle();

        // Randomized traffic with random backpressure and gaps.
        mode = 1;
        for (int n = 0; n < 40; n++) begin
            send_window(rand_win(1'($urandom_range(0, 1))), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
        end
        mode = 0;
        wait_idle();

        // Reset during MAG discards the in-flight window.
        send_window(rand_win(1'b0), 1'b0);
        @(negedge clk); #3;
        n_rst = 1'b0;
        #1;
        check({clr0, val0, busy0, clr1, val1, busy1} == 6'd0, "rst_mid_ctrl", int'({clr0, val0, busy0}), 0);
        check(edge0 == 16'd0 && cnt0 == 16'd0 && cnt1 == 16'd0, "rst_mid_data", int'(cnt0), 0);
        repeat (2) @(negedge clk);
        #1 n_rst = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
            check(!val0 && !clr0 && !busy0, "post_rst_idle", int'({val0, clr0, busy0}), 0);
        end
        check(cnt0 == 16'd0, "post_rst_count", int'(cnt0), 0);

        // Normal operation after reset.
        send_window(cols_win(10, 10, 20, 20), 1'b1);
        send_window(rand_win(1'b1), 1'b0);

        for (k = 0; k < 500 && (exp0_q.size() != 0 || exp1_q.size() != 0 || busy0); k++) begin
            @(negedge clk); #1;
        end
        check(exp0_q.size() == 0, "drain_sat", exp0_q.size(), 0);
        check(exp1_q.size() == 0, "drain_bin", exp1_q.size(), 0);
        repeat (2) @(negedge clk);
        #1;
        check(cnt0 == 16'd2 && cnt1 == 16'd2, "final_count", int'(cnt0), 2);
        check(n_clears == n_sent, "clear_total", n_clears, n_sent);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
